passcode_checker: RTL and testbench

PASSCODE_CHECKER -- requirements
Module: passcode_checker

---
 rtl/passcode_checker_pkg.sv | 30 +++
 rtl/digit_shift_reg.sv | 66 ++++++
 rtl/passcode_checker.sv | 171 +++++++++++++++++
 tb/tb_passcode_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/passcode_checker_pkg.sv
// Shared definitions for the passcode checker: FSM state codes,
// parameter defaults and small helpers used by the datapath.
package desc_lib;

  // FSM state codes; these values are visible on state_out.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ARMED   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam int DEF_PW_LEN         = 8;
  localparam int DEF_MAX_TRIES      = 3;
  localparam int DEF_UNLOCK_CYCLES  = 1000;
  localparam int DEF_LOCKOUT_CYCLES = 5000;

  // Width of the digit counter exposed on digit_cnt.
  localparam int CNT_W = 4;

  // A key code is a usable digit only in the BCD range 0-9.
  function automatic logic is_bcd(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Digit capture: rising-edge detect on key_valid, BCD range check,
// MSB-first nibble shift and a counter that saturates at PW_LEN.
// Captured digits stop being accepted once the register is full, so the
// owner must clear the count (clr_cnt) or everything (clr_all) to restart.
module digit_shift_reg
  import desc_lib::*;
#(
  parameter int PW_LEN = DEF_PW_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  en,
  input  logic                  clr_cnt,
  input  logic                  clr_all,
  output logic [PW_LEN*4-1:0]   value,
  output logic [CNT_W-1:0]      count,
  output logic                  full
);

  localparam int W = PW_LEN * 4;

  logic            kv_q, kv_d;
  logic [W-1:0]    val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            key_edge;
  logic            capture;

  // Next-state for edge detect, shift register and saturating count;
  // a clear in the same cycle as a digit edge takes priority.
  always_comb begin
    kv_d     = key_valid;
    val_d    = val_q;
    cnt_d    = cnt_q;
    full     = (cnt_q == CNT_W'(PW_LEN));
    key_edge = key_valid & ~kv_q;
    capture  = en & key_edge & is_bcd(key_code) & ~full & ~clr_cnt & ~clr_all;
    if (clr_all) begin
      val_d = '0;
      cnt_d = '0;
    end else if (clr_cnt) begin
      cnt_d = '0;
    end else if (capture) begin
      val_d = (val_q << 4) | W'(key_code);
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Capture registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kv_q  <= 1'b0;
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      kv_q  <= kv_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign value = val_q;
  assign count = cnt_q;

endmodule

// File: rtl/passcode_checker.sv
// Keypad passcode checker. Digits are first enrolled into the stored
// passcode, then typed entries are compared against it. A match opens the
// lock for UNLOCK_CYCLES; MAX_TRIES consecutive mismatches raise the alarm
// for LOCKOUT_CYCLES, during which keys are ignored.
//
// Handshake: there is no valid/ready pair here. key_valid is a level from
// the encoder; each low-to-high transition offers key_code exactly once and
// nothing back-pressures the encoder.
module passcode_checker
  import desc_lib::*;
#(
  parameter int PW_LEN         = DEF_PW_LEN,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       enroll_req,
  input  logic       clear_entry,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic [1:0] state_out,
  output logic [3:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  localparam int W       = PW_LEN * 4;
  localparam int TMR_MAX = max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       fail_q, fail_d;
  logic             err_q, err_d;

  // Stored passcode datapath.
  logic [W-1:0]     pw_val;
  logic [CNT_W-1:0] pw_cnt;
  logic             pw_full;
  logic             pw_en, pw_clr_cnt, pw_clr_all;

  // Typed entry datapath.
  logic [W-1:0]     entry_val;
  logic [CNT_W-1:0] ent_cnt;
  logic             ent_full;
  logic             ent_en, ent_clr_cnt, ent_clr_all;

  logic             code_match;

  assign pw_en      = (state_q == ST_EMPTY);
  assign ent_en     = (state_q == ST_ARMED);
  assign code_match = (entry_val == pw_val);
  assign ent_clr_cnt = 1'b0;

  digit_shift_reg #(.PW_LEN(PW_LEN)) u_pw_reg (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .en        (pw_en),
    .clr_cnt   (pw_clr_cnt),
    .clr_all   (pw_clr_all),
    .value     (pw_val),
    .count     (pw_cnt),
    .full      (pw_full)
  );

  digit_shift_reg #(.PW_LEN(PW_LEN)) u_entry_reg (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .en        (ent_en),
    .clr_cnt   (ent_clr_cnt),
    .clr_all   (ent_clr_all),
    .value     (entry_val),
    .count     (ent_cnt),
    .full      (ent_full)
  );

  // Next-state, timer, failure count and error pulse.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fail_d      = fail_q;
    err_d       = 1'b0;
    pw_clr_cnt  = 1'b0;
    pw_clr_all  = 1'b0;
    ent_clr_all = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (clear_entry) begin
          pw_clr_all = 1'b1;
        end else if (pw_full) begin
          // Keep the enrolled digits, restart the count for the entries.
          state_d    = ST_ARMED;
          pw_clr_cnt = 1'b1;
        end
      end
      ST_ARMED: begin
        if (clear_entry) begin
          ent_clr_all = 1'b1;
        end else if (ent_full) begin
          ent_clr_all = 1'b1;
          if (code_match) begin
            state_d = ST_OPEN;
            timer_d = TMR_W'(UNLOCK_CYCLES - 1);
            fail_d  = 2'd0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + 2'd1;
            if (int'(fail_q) + 1 >= MAX_TRIES) begin
              state_d = ST_LOCKOUT;
              timer_d = TMR_W'(LOCKOUT_CYCLES - 1);
            end
          end
        end
      end
      ST_OPEN: begin
        if (enroll_req) begin
          // Re-enrollment wipes the old passcode before new digits arrive.
          state_d    = ST_EMPTY;
          pw_clr_all = 1'b1;
          timer_d    = '0;
        end else if (timer_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ARMED;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      timer_q <= '0;
      fail_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign unlock    = (state_q == ST_OPEN);
  assign alarm     = (state_q == ST_LOCKOUT);
  assign err       = err_q;
  assign state_out = state_q;
  assign digit_cnt = (state_q == ST_EMPTY) ? pw_cnt : ent_cnt;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: scenario tasks drive keypad presses and
// compare against a digit-level model of the lock.
module tb_passcode_checker;

  localparam int PW_LEN         = 8;
  localparam int MAX_TRIES      = 3;
  localparam int UNLOCK_CYCLES  = 4;
  localparam int LOCKOUT_CYCLES = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       enroll_req;
  logic       clear_entry;
  logic       unlock;
  logic       alarm;
  logic       err;
  logic [1:0] state_out;
  logic [3:0] digit_cnt;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  // Output activity counters, sampled mid-cycle.
  int unlock_hi = 0;
  int alarm_hi  = 0;
  int err_hi    = 0;

  // Reference model: stored passcode digits, current attempt, failures.
  int pw_digits[PW_LEN];
  int cur[PW_LEN];
  int m_fail = 0;

  passcode_checker #(
    .PW_LEN         (PW_LEN),
    .MAX_TRIES      (MAX_TRIES),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .enroll_req  (enroll_req),
    .clear_entry (clear_entry),
    .unlock      (unlock),
    .alarm       (alarm),
    .err         (err),
    .state_out   (state_out),
    .digit_cnt   (digit_cnt),
    .fail_cnt    (fail_cnt)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count cycles each output spends high.
  always @(posedge clk) begin
    #2;
    if (unlock === 1'b1) unlock_hi++;
    if (alarm === 1'b1)  alarm_hi++;
    if (err === 1'b1)    err_hi++;
  end

  // Stored passcode as a number: first digit is the most significant.
  function automatic logic [31:0] pw_value();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < PW_LEN; i++) v = v * 32'd16 + 32'(pw_digits[i]);
    return v;
  endfunction

  // One key press: hold key_valid for 'hold' cycles, then one cycle low.
  task automatic press(input int d, input int hold);
    key_code  = 4'(d);
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0; key_code = 4'd0; enroll_req = 1'b0; clear_entry = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_out); end
    checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL reset_unlock got %b want 0", unlock); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b want 0", alarm); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_digit_cnt got %0d want 0", digit_cnt); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL reset_fail_cnt got %0d want 0", fail_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d want 0", state_out); end
    m_fail = 0;
  endtask

  task automatic test_enroll(input bit random_code);
    if (random_code) begin
      for (int i = 0; i < PW_LEN; i++) pw_digits[i] = $urandom_range(0, 9);
    end else begin
      pw_digits = '{2, 1, 9, 3, 5, 4, 8, 8};
    end
    for (int i = 0; i < PW_LEN; i++) begin
      press(pw_digits[i], $urandom_range(1, 3));
      if (i < PW_LEN - 1) begin
        checks++;
        if (digit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL enroll_cnt digit %0d got %0d want %0d", i, digit_cnt, i + 1); end
      end
    end
    @(negedge clk);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL enroll_state got %0d want 1", state_out); end
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL enroll_cnt_after got %0d want 0", digit_cnt); end
    checks++; if (dut.pw_val !== pw_value()) begin errors++; $display("FAIL enroll_pw got %h want %h", dut.pw_val, pw_value()); end
  endtask

  // Types cur[] as an attempt and checks the outcome against the model.
  task automatic enter_attempt(input bit inject_bad, input bit poke_lock);
    int  bad_pos;
    int  u0, a0, e0;
    int  exp_u, exp_a, exp_e;
    bit  match;
    bit  lock;
    bad_pos = $urandom_range(0, PW_LEN - 2);
    for (int i = 0; i < PW_LEN - 1; i++) begin
      if (inject_bad && i == bad_pos) press($urandom_range(10, 15), 1);
      press(cur[i], $urandom_range(1, 3));
      checks++;
      if (digit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL entry_cnt digit %0d got %0d want %0d", i, digit_cnt, i + 1); end
    end
    match = 1'b1;
    for (int i = 0; i < PW_LEN; i++) if (cur[i] != pw_digits[i]) match = 1'b0;
    lock = 1'b0;
    if (match) begin
      exp_u = UNLOCK_CYCLES; exp_e = 0; exp_a = 0; m_fail = 0;
    end else begin
      exp_u = 0; exp_e = 1; m_fail++;
      if (m_fail >= MAX_TRIES) begin exp_a = LOCKOUT_CYCLES; lock = 1'b1; end
      else exp_a = 0;
    end
    u0 = unlock_hi; a0 = alarm_hi; e0 = err_hi;
    press(cur[PW_LEN - 1], 1);
    if (!match) begin
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", err); end
      checks++; if (fail_cnt !== 2'(m_fail)) begin errors++; $display("FAIL fail_cnt_on_err got %0d want %0d", fail_cnt, m_fail); end
    end
    if (lock) begin
      checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL lock_state got %0d want 3", state_out); end
      checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL lock_alarm got %b want 1", alarm); end
      if (poke_lock) begin
        press($urandom_range(0, 9), 1);
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL lock_key_ignored got %0d want 0", digit_cnt); end
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL lock_state_hold got %0d want 3", state_out); end
      end
      m_fail = 0;
    end
    repeat (12) @(negedge clk);
    checks++; if (unlock_hi - u0 != exp_u) begin errors++; $display("FAIL unlock_cycles got %0d want %0d", unlock_hi - u0, exp_u); end
    checks++; if (alarm_hi - a0 != exp_a) begin errors++; $display("FAIL alarm_cycles got %0d want %0d", alarm_hi - a0, exp_a); end
    checks++; if (err_hi - e0 != exp_e) begin errors++; $display("FAIL err_cycles got %0d want %0d", err_hi - e0, exp_e); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL attempt_end_state got %0d want 1", state_out); end
    checks++; if (fail_cnt !== 2'(m_fail)) begin errors++; $display("FAIL attempt_fail_cnt got %0d want %0d", fail_cnt, m_fail); end
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL attempt_digit_cnt got %0d want 0", digit_cnt); end
  endtask

  task automatic test_unlock();
    cur = pw_digits;
    enter_attempt(1'b0, 1'b0);
  endtask

  task automatic test_lockout();
    int j;
    for (int k = 0; k < MAX_TRIES; k++) begin
      cur = pw_digits;
      j = $urandom_range(0, PW_LEN - 1);
      cur[j] = (cur[j] + 1 + $urandom_range(0, 8)) % 10;
      enter_attempt(1'b0, k == MAX_TRIES - 1);
    end
  endtask

  task automatic test_held_key();
    key_code = 4'd7;
    key_valid = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (digit_cnt !== 4'd1) begin errors++; $display("FAIL held_key_cnt got %0d want 1", digit_cnt); end
    key_valid = 1'b0;
    @(negedge clk);
    press(12, 3);
    checks++; if (digit_cnt !== 4'd1) begin errors++; $display("FAIL invalid_code_cnt got %0d want 1", digit_cnt); end
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL clear_cnt got %0d want 0", digit_cnt); end
    key_code = 4'd3; key_valid = 1'b1; clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    key_valid = 1'b0;
    @(negedge clk);
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL clear_beats_digit got %0d want 0", digit_cnt); end
  endtask

  task automatic test_clear_then_unlock();
    for (int i = 0; i < 5; i++) press($urandom_range(0, 9), $urandom_range(1, 2));
    checks++; if (digit_cnt !== 4'd5) begin errors++; $display("FAIL partial_cnt got %0d want 5", digit_cnt); end
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL partial_clear got %0d want 0", digit_cnt); end
    cur = pw_digits;
    enter_attempt(1'b0, 1'b0);
  endtask

  task automatic test_enroll_req();
    enroll_req = 1'b1;
    @(negedge clk);
    enroll_req = 1'b0;
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL enroll_armed_ignored got %0d want 1", state_out); end
    checks++; if (dut.pw_val !== pw_value()) begin errors++; $display("FAIL enroll_armed_pw got %h want %h", dut.pw_val, pw_value()); end
    for (int i = 0; i < PW_LEN - 1; i++) press(pw_digits[i], 1);
    press(pw_digits[PW_LEN - 1], 1);
    checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL open_before_enroll got %b want 1", unlock); end
    enroll_req = 1'b1;
    @(negedge clk);
    enroll_req = 1'b0;
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL enroll_open_state got %0d want 0", state_out); end
    checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL enroll_open_unlock got %b want 0", unlock); end
    checks++; if (dut.pw_val !== 32'd0) begin errors++; $display("FAIL enroll_open_pw got %h want 0", dut.pw_val); end
    repeat (UNLOCK_CYCLES + 2) @(negedge clk);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL enroll_stays_empty got %0d want 0", state_out); end
  endtask

  task automatic test_reset_mid_open();
    for (int i = 0; i < PW_LEN - 1; i++) press(pw_digits[i], 1);
    press(pw_digits[PW_LEN - 1], 1);
    checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL open_before_rst got %b want 1", unlock); end
    #2 rst = 1'b1;
    #1;
    checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL rst_unlock got %b want 0", unlock); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_out); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm got %b want 0", alarm); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dut.pw_val !== 32'd0) begin errors++; $display("FAIL rst_pw got %h want 0", dut.pw_val); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL rst_fail_cnt got %0d want 0", fail_cnt); end
    m_fail = 0;
  endtask

  task automatic test_random();
    test_enroll(1'b1);
    for (int n = 0; n < 10; n++) begin
      cur = pw_digits;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < PW_LEN; i++) cur[i] = $urandom_range(0, 9);
      end
      enter_attempt($urandom_range(0, 1) == 1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_enroll(1'b0);
    test_unlock();
    test_lockout();
    test_held_key();
    test_clear_then_unlock();
    test_enroll_req();
    test_enroll(1'b0);
    test_reset_mid_open();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
